// File: rtl/spm_wb_multiplier_if.sv
// Wishbone slave bus bundle for the serial-parallel multiplier.
// Master drives the request, slave returns ack and read data.
interface spm_wb_multiplier_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/spm_wb_multiplier.sv
// Wishbone-slave serial-parallel multiplier, one product bit per cycle.
// Unsigned or two's-complement, with CTRL/STATUS, W1C flags and irq.
module spm_wb_multiplier #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  spm_wb_multiplier_if.slave   bus,
  output logic                 irq_o
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  localparam logic [6:0] LAST = 7'(2 * WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [WIDTH-1:0]   xr;
  logic [WIDTH-1:0]   yr;
  logic [WIDTH:0]     acc;
  logic [2*WIDTH-1:0] pr;
  logic [2*WIDTH-1:0] p;
  logic [6:0]         cnt;
  logic               signed_mode;
  logic               irq_en;
  logic               done;
  logic               err;

  logic        busy;
  logic        valid;
  logic        take;
  logic        wr;
  logic [2:0]  off;
  logic        hit_x;
  logic        hit_y;
  logic        hit_lo;
  logic        hit_hi;
  logic        hit_ctl;
  logic        start;
  logic [31:0] xm;
  logic [31:0] ym;
  logic [31:0] rdata;
  logic [63:0] p_ext;

  logic [WIDTH+1:0] xe;
  logic [WIDTH+1:0] sum;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? nw[8*i +: 8]
                          : old[8*i +: 8];
    end
    return r;
  endfunction

  assign busy  = (state != IDLE);
  assign valid = bus.wbs_cyc_i & bus.wbs_stb_i &
                 (bus.wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign take  = valid & ~bus.wbs_ack_o;
  assign wr    = take & bus.wbs_we_i;
  assign off   = bus.wbs_adr_i[4:2];

  assign hit_x   = (off == 3'd0);
  assign hit_y   = (off == 3'd1);
  assign hit_lo  = (off == 3'd2);
  assign hit_hi  = (off == 3'd3);
  assign hit_ctl = (off == 3'd4);
  assign start   = wr & hit_ctl & bus.wbs_dat_i[0];

  assign xm = merge(32'(x), bus.wbs_dat_i, bus.wbs_sel_i);
  assign ym = merge(32'(y), bus.wbs_dat_i, bus.wbs_sel_i);
  assign p_ext = 64'(p);

  // X cell row: the MSB carries negative weight in signed mode
  assign xe  = signed_mode ? {{2{xr[WIDTH-1]}}, xr}
                           : {2'b00, xr};
  assign sum = {acc[WIDTH], acc} + (yr[0] ? xe : '0);

  assign irq_o = done & irq_en;

  // Register read mux; start bit always reads back as zero
  always_comb begin
    rdata = '0;
    unique case (1'b1)
      hit_x:   rdata = 32'(x);
      hit_y:   rdata = 32'(y);
      hit_lo:  rdata = p_ext[31:0];
      hit_hi:  rdata = p_ext[63:32];
      hit_ctl: rdata = {26'd0, err, done, busy,
                        irq_en, signed_mode, 1'b0};
      default: rdata = '0;
    endcase
  end

  // One-cycle ack, never on two consecutive cycles
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
    end else begin
      bus.wbs_ack_o <= take;
      bus.wbs_dat_o <= (take & ~bus.wbs_we_i) ? rdata : '0;
    end
  end

  // Sequencer, serial datapath and register writes
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      xr          <= '0;
      yr          <= '0;
      acc         <= '0;
      pr          <= '0;
      p           <= '0;
      cnt         <= '0;
      signed_mode <= 1'b0;
      irq_en      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            xr    <= x;
            yr    <= y;
            acc   <= '0;
            pr    <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= sum[WIDTH+1:1];
          pr  <= {sum[0], pr[2*WIDTH-1:1]};
          yr  <= {signed_mode & yr[WIDTH-1],
                  yr[WIDTH-1:1]};
          cnt <= cnt + 7'd1;
          if (cnt == LAST) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          p     <= pr;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr && !busy) begin
        if (hit_x) begin
          x <= xm[WIDTH-1:0];
        end
        if (hit_y) begin
          y <= ym[WIDTH-1:0];
        end
        if (hit_ctl) begin
          signed_mode <= bus.wbs_dat_i[1];
          irq_en      <= bus.wbs_dat_i[2];
        end
      end

      if (state == FINISH) begin
        done <= 1'b1;
      end else if (wr && hit_ctl &&
                   ((start && !busy) ||
                    bus.wbs_dat_i[4])) begin
        done <= 1'b0;
      end

      if (wr && busy && (hit_x || hit_y || start)) begin
        err <= 1'b1;
      end else if (wr && hit_ctl && bus.wbs_dat_i[5]) begin
        err <= 1'b0;
      end
    end
  end

  logic unused;
  assign unused = ^{bus.wbs_adr_i[1:0], xm, ym};

endmodule
